// File: rtl/sliding_window_gen_pkg.sv
// Shared constants and types for the 3x3 sliding window generator.
package sliding_window_gen_pkg;

  // Default pixel width used by the window generator and its interface.
  localparam int DEF_DW = 8;

  // Window positions, row-major. These map onto the filter's
  // sw_pixels1..sw_pixels9 inputs one-for-one.
  localparam int WIN_TL = 1;  // top-left, oldest row, oldest column
  localparam int WIN_TC = 2;
  localparam int WIN_TR = 3;
  localparam int WIN_ML = 4;
  localparam int WIN_C  = 5;  // centre pixel
  localparam int WIN_MR = 6;
  localparam int WIN_BL = 7;
  localparam int WIN_BC = 8;
  localparam int WIN_BR = 9;  // bottom-right, the pixel just accepted

  // One pixel at the default width.
  typedef logic [DEF_DW-1:0] pixel_t;

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, the window
// generator and the downstream 3x3 filter.
//
// Handshake: a pixel transfers on every rising clk edge where pix_valid=1
// and clear=0. There is no ready; the generator accepts every such pixel.
// On the output side win_valid=1 marks a cycle in which win1..win9 hold a
// complete 3x3 window, and the consumer must take it in that same cycle.
interface sliding_window_gen_if #(
  parameter int DW = sliding_window_gen_pkg::DEF_DW
);
  import sliding_window_gen_pkg::*;

  logic          clear;
  logic [DW-1:0] pix_in;
  logic          pix_valid;

  logic [DW-1:0] win1;
  logic [DW-1:0] win2;
  logic [DW-1:0] win3;
  logic [DW-1:0] win4;
  logic [DW-1:0] win5;
  logic [DW-1:0] win6;
  logic [DW-1:0] win7;
  logic [DW-1:0] win8;
  logic [DW-1:0] win9;
  logic          win_valid;
  logic          frame_done;

  // Pixel source / test side.
  modport master (
    output clear, pix_in, pix_valid,
    input  win1, win2, win3, win4, win5, win6, win7, win8, win9,
    input  win_valid, frame_done
  );

  // Window generator side.
  modport slave (
    input  clear, pix_in, pix_valid,
    output win1, win2, win3, win4, win5, win6, win7, win8, win9,
    output win_valid, frame_done
  );

endinterface

// File: rtl/sliding_window_gen_line_buffer.sv
// Single-row pixel store: combinational read at addr, synchronous write
// at the same addr. A read in the cycle of a write returns the old value,
// which is what lets one address both feed the window and shift rows.
module sw_line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Row storage; contents are never reset, stale data is masked upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sliding_window_gen.sv
// 3x3 sliding window generator. Takes a raster-order pixel stream and
// emits a registered 3x3 window for every interior position, plus a
// one-cycle frame_done after the last pixel of each frame.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  sliding_window_gen_if.slave bus
);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DW-1:0] win_q [WIN_TL:WIN_BR];
  logic          win_valid_q;
  logic          frame_done_q;

  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          interior;
  logic [DW-1:0] lb0_rd;  // pixel one row above the current position
  logic [DW-1:0] lb1_rd;  // pixel two rows above the current position

  // A pixel is taken only when no restart is requested in the same cycle.
  assign accept   = bus.pix_valid && !bus.clear;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  // Columns 0/1 and rows 0/1 still carry stale data in part of the window.
  assign interior = (row >= RW'(2)) && (col >= CW'(2));

  // lb0 holds the previous row; its old entry moves down into lb1.
  sw_line_buffer #(
    .DW    (DW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col),
    .wr_data (bus.pix_in),
    .rd_data (lb0_rd)
  );

  sw_line_buffer #(
    .DW    (DW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Raster position: col wraps into row, row wraps at end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shift: each row moves one column left, new column enters right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = WIN_TL; i <= WIN_BR; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      win_q[WIN_TL] <= win_q[WIN_TC];
      win_q[WIN_TC] <= win_q[WIN_TR];
      win_q[WIN_TR] <= lb1_rd;
      win_q[WIN_ML] <= win_q[WIN_C];
      win_q[WIN_C]  <= win_q[WIN_MR];
      win_q[WIN_MR] <= lb0_rd;
      win_q[WIN_BL] <= win_q[WIN_BC];
      win_q[WIN_BC] <= win_q[WIN_BR];
      win_q[WIN_BR] <= bus.pix_in;
    end
  end

  // Strobes follow the accepted pixel by one cycle; clear and idle drop them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= accept && interior;
      frame_done_q <= accept && last_col && last_row;
    end
  end

  assign bus.win1       = win_q[WIN_TL];
  assign bus.win2       = win_q[WIN_TC];
  assign bus.win3       = win_q[WIN_TR];
  assign bus.win4       = win_q[WIN_ML];
  assign bus.win5       = win_q[WIN_C];
  assign bus.win6       = win_q[WIN_MR];
  assign bus.win7       = win_q[WIN_BL];
  assign bus.win8       = win_q[WIN_BC];
  assign bus.win9       = win_q[WIN_BR];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen on a 4x4 image. The reference keeps the
// pixels of the current frame in an array and builds each expected window
// directly from image coordinates.
module tb_sliding_window_gen;
  import sliding_window_gen_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 9 * DEF_DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sliding_window_gen_if #(.DW(DEF_DW)) bus ();

  sliding_window_gen #(
    .DW    (DEF_DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int             tests;
  int             fails;
  int             idx;          // raster index of the next pixel to accept
  pixel_t         cur [W*H];    // current frame as seen by the model
  logic [WW-1:0]  exp_q [$];
  logic [WW-1:0]  log_q [$];
  int             win_cnt;
  int             fd_cnt;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] win_now();
    return {bus.win1, bus.win2, bus.win3, bus.win4, bus.win5,
            bus.win6, bus.win7, bus.win8, bus.win9};
  endfunction

  // Window whose bottom-right corner is (r,c), rows r-2..r, cols c-2..c.
  function automatic logic [WW-1:0] window_at(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) begin
      w = {w[WW-DEF_DW-1:0], cur[(r - 2 + i / 3) * W + (c - 2 + i % 3)]};
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    return {a0[7:0], a1[7:0], a2[7:0], a3[7:0], a4[7:0],
            a5[7:0], a6[7:0], a7[7:0], a8[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic begin_test();
    log_q.delete();
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  task automatic observe();
    if (bus.win_valid) begin
      win_cnt++;
      log_q.push_back(win_now());
    end
    if (bus.frame_done) fd_cnt++;
  endtask

  // One clock with the given inputs; checks the registered response.
  task automatic step(input bit v, input bit clr, input logic [7:0] px);
    bit            exp_v;
    bit            exp_fd;
    int            r;
    int            c;
    logic [WW-1:0] exp_w;
    bus.pix_valid = v;
    bus.clear     = clr;
    bus.pix_in    = px;
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (clr) begin
      idx = 0;
    end else if (v) begin
      r = idx / W;
      c = idx % W;
      cur[idx] = px;
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(window_at(r, c));
        exp_v = 1'b1;
      end
      exp_fd = (idx == W * H - 1);
      idx = (idx + 1) % (W * H);
    end
    @(posedge clk);
    #1;
    check("win_valid", WW'(bus.win_valid), WW'(exp_v));
    check("frame_done", WW'(bus.frame_done), WW'(exp_fd));
    if (exp_v) begin
      exp_w = exp_q.pop_front();
      if (bus.win_valid) check("window", win_now(), exp_w);
    end
    observe();
  endtask

  // Idle cycles: no strobes, and the window must not move.
  task automatic idle(input int n);
    logic [WW-1:0] held;
    for (int i = 0; i < n; i++) begin
      held = win_now();
      bus.pix_valid = 1'b0;
      bus.clear     = 1'b0;
      bus.pix_in    = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("idle_win_valid", WW'(bus.win_valid), '0);
      check("idle_frame_done", WW'(bus.frame_done), '0);
      check("idle_hold", win_now(), held);
      observe();
    end
  endtask

  task automatic stream_frame(input int base, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, 8'(base + i));
      if (gaps && $urandom_range(0, 2) != 0) idle($urandom_range(1, 5));
    end
  endtask

  task automatic check_log(input string tag, input int k, input logic [WW-1:0] exp);
    logic [WW-1:0] obs;
    obs = (log_q.size() > k) ? log_q[k] : 'x;
    check(tag, obs, exp);
  endtask

  task automatic check_frame(input string tag, input int wins, input int fds);
    check({tag, "_win_count"}, WW'(win_cnt), WW'(wins));
    check({tag, "_done_count"}, WW'(fd_cnt), WW'(fds));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [WW-1:0] first_w;
    logic [WW-1:0] last_w;
    tests = 0;
    fails = 0;
    idx   = 0;
    first_w = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    last_w  = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);

    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_win_valid", WW'(bus.win_valid), '0);
    check("reset_frame_done", WW'(bus.frame_done), '0);
    check("reset_window", win_now(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame.
    begin_test();
    stream_frame(0, 1'b0);
    idle(1);
    check_frame("cont", 4, 1);
    check_log("cont_first", 0, first_w);
    check_log("cont_last", 3, last_w);

    // Same frame with random idle gaps.
    begin_test();
    stream_frame(0, 1'b1);
    idle(1);
    check_frame("gaps", 4, 1);
    check_log("gaps_first", 0, first_w);
    check_log("gaps_last", 3, last_w);

    // Two frames back-to-back, no bubble between them.
    begin_test();
    stream_frame(0, 1'b0);
    stream_frame(100, 1'b0);
    idle(1);
    check_frame("b2b", 8, 2);
    check_log("b2b_fifth", 4, pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // Random pixel values with random gaps.
    begin_test();
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 5));
    end
    idle(1);
    check_frame("rand", 4, 1);

    // Asynchronous reset in the middle of a frame, after pixel 9.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i));
    bus.pix_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_win_valid", WW'(bus.win_valid), '0);
    check("midrst_frame_done", WW'(bus.frame_done), '0);
    check("midrst_window", win_now(), '0);
    #3;
    rst_n = 1'b1;
    idx = 0;
    exp_q.delete();
    begin_test();
    stream_frame(0, 1'b0);
    idle(1);
    check_frame("rst", 4, 1);
    check_log("rst_first", 0, first_w);
    check_log("rst_last", 3, last_w);

    // Clear together with a valid pixel 6: pixel dropped, window held.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'd6);
    check("clear_hold_win9", WW'(bus.win9), WW'(8'd5));
    begin_test();
    stream_frame(0, 1'b0);
    idle(1);
    check_frame("clr", 4, 1);
    check_log("clr_first", 0, first_w);
    check_log("clr_last", 3, last_w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
